// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register and register-file write-data select.
// Adds a write-once guarantee under stall, bubble insertion on flush, a retired-instruction
// counter and sticky halt/error status. All outputs come from stage registers only.
module wb_stage_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RA_W   = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_regwrite,
  input  logic              in_regdst,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [RA_W-1:0]   in_rs,
  input  logic [2:0]        in_src,
  input  logic [1:0]        in_cmp,
  input  logic              in_zero,
  input  logic              in_p,
  input  logic              in_cout,
  input  logic              in_halt,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_nxt_pc,
  output logic              wr_en,
  output logic [RA_W-1:0]   wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retired,
  output logic              halted,
  output logic              err
);

  localparam logic [2:0] SrcAlu  = 3'd0;
  localparam logic [2:0] SrcMem  = 3'd1;
  localparam logic [2:0] SrcSlbi = 3'd2;
  localparam logic [2:0] SrcCmp  = 3'd3;
  localparam logic [2:0] SrcBtr  = 3'd4;
  localparam logic [2:0] SrcPc   = 3'd5;
  localparam logic [2:0] SrcImm  = 3'd6;
  localparam logic [2:0] SrcRsv  = 3'd7;

  localparam logic [1:0] CmpSeq = 2'd0;
  localparam logic [1:0] CmpSlt = 2'd1;
  localparam logic [1:0] CmpSle = 2'd2;
  localparam logic [1:0] CmpSco = 2'd3;

  logic              valid_q, fresh_q, regwrite_q, regdst_q;
  logic [RA_W-1:0]   rd_q, rs_q;
  logic [2:0]        src_q;
  logic [1:0]        cmp_q;
  logic              zero_q, p_q, cout_q, halt_q;
  logic [DATA_W-1:0] alu_q, mem_q, imm_q, nxt_pc_q;
  logic [CNT_W-1:0]  retired_q;
  logic              halted_q, err_q;

  logic              resident;
  logic              retire;
  logic              cmp_bit;
  logic [DATA_W-1:0] btr_val;

  // An entry retires in the single cycle it is resident and fresh.
  assign resident = valid_q & fresh_q;
  assign retire   = resident & ~halted_q;

  // Stage register capture/hold/bubble plus sticky status and retirement counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      fresh_q    <= 1'b0;
      regwrite_q <= 1'b0;
      regdst_q   <= 1'b0;
      rd_q       <= '0;
      rs_q       <= '0;
      src_q      <= '0;
      cmp_q      <= '0;
      zero_q     <= 1'b0;
      p_q        <= 1'b0;
      cout_q     <= 1'b0;
      halt_q     <= 1'b0;
      alu_q      <= '0;
      mem_q      <= '0;
      imm_q      <= '0;
      nxt_pc_q   <= '0;
      retired_q  <= '0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (resident && halt_q) halted_q <= 1'b1;
      if (resident && (src_q == SrcRsv)) err_q <= 1'b1;
      if (flush) begin
        // Bubble: payload fields are left as-is, they are ignored while invalid.
        valid_q <= 1'b0;
        fresh_q <= 1'b0;
      end else if (!stall) begin
        valid_q    <= in_valid;
        fresh_q    <= 1'b1;
        regwrite_q <= in_regwrite;
        regdst_q   <= in_regdst;
        rd_q       <= in_rd;
        rs_q       <= in_rs;
        src_q      <= in_src;
        cmp_q      <= in_cmp;
        zero_q     <= in_zero;
        p_q        <= in_p;
        cout_q     <= in_cout;
        halt_q     <= in_halt;
        alu_q      <= in_alu;
        mem_q      <= in_mem;
        imm_q      <= in_imm;
        nxt_pc_q   <= in_nxt_pc;
      end else begin
        fresh_q <= 1'b0;
      end
    end
  end

  // Compare condition and bit-reversed ALU value.
  always_comb begin
    cmp_bit = 1'b0;
    unique case (cmp_q)
      CmpSeq:  cmp_bit = zero_q;
      CmpSlt:  cmp_bit = p_q;
      CmpSle:  cmp_bit = p_q | zero_q;
      CmpSco:  cmp_bit = cout_q;
      default: cmp_bit = 1'b0;
    endcase
    btr_val = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      btr_val[i] = alu_q[int'(DATA_W) - 1 - i];
    end
  end

  // Write-data select; the reserved source falls back to ALU data with the write suppressed.
  always_comb begin
    wr_data = alu_q;
    unique case (src_q)
      SrcAlu:  wr_data = alu_q;
      SrcMem:  wr_data = mem_q;
      SrcSlbi: wr_data = alu_q | imm_q;
      SrcCmp:  wr_data = {{(DATA_W-1){1'b0}}, cmp_bit};
      SrcBtr:  wr_data = btr_val;
      SrcPc:   wr_data = nxt_pc_q;
      SrcImm:  wr_data = imm_q;
      SrcRsv:  wr_data = alu_q;
      default: wr_data = alu_q;
    endcase
  end

  assign wr_reg    = regdst_q ? rd_q : rs_q;
  assign wr_en     = retire & regwrite_q & (src_q != SrcRsv);
  assign fwd_valid = valid_q & regwrite_q;
  // Count includes the entry retiring this cycle so it lines up with wr_en.
  assign retired   = retired_q + CNT_W'(retire);
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 4;

  typedef struct {
    logic          rst, valid, stall, flush, regwrite, regdst;
    logic [AW-1:0] rd, rs;
    logic [2:0]    src;
    logic [1:0]    cmp;
    logic          zero, p, cout, halt;
    logic [DW-1:0] alu, mem, imm, pc;
  } stim_t;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic          fwd_valid;
    logic [CW-1:0] retired;
    logic          halted, err;
    logic          known;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, stall, flush, in_regwrite, in_regdst;
  logic [AW-1:0] in_rd, in_rs;
  logic [2:0] in_src;
  logic [1:0] in_cmp;
  logic in_zero, in_p, in_cout, in_halt;
  logic [DW-1:0] in_alu, in_mem, in_imm, in_nxt_pc;
  logic wr_en, fwd_valid, halted, err;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] retired;

  int n_checks = 0;
  int n_err = 0;
  exp_t sb[$];

  // Reference model: one resident entry plus status, updated per clock.
  stim_t m_ent;
  bit m_fresh = 0, m_halted = 0, m_err = 0, m_known = 0;
  int m_count = 0;

  wb_stage_pipe #(.DATA_W(DW), .RA_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_regwrite(in_regwrite), .in_regdst(in_regdst), .in_rd(in_rd), .in_rs(in_rs),
    .in_src(in_src), .in_cmp(in_cmp), .in_zero(in_zero), .in_p(in_p), .in_cout(in_cout),
    .in_halt(in_halt), .in_alu(in_alu), .in_mem(in_mem), .in_imm(in_imm),
    .in_nxt_pc(in_nxt_pc), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .fwd_valid(fwd_valid), .retired(retired), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.valid = ($urandom_range(0, 4) != 0);
    s.stall = ($urandom_range(0, 3) == 0);
    s.flush = ($urandom_range(0, 7) == 0);
    s.rst = ($urandom_range(0, 39) == 0);
    s.regwrite = 1'($urandom);
    s.regdst = 1'($urandom);
    s.rd = AW'($urandom);
    s.rs = AW'($urandom);
    s.src = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
    s.cmp = 2'($urandom);
    s.zero = 1'($urandom);
    s.p = 1'($urandom);
    s.cout = 1'($urandom);
    s.halt = ($urandom_range(0, 29) == 0);
    s.alu = DW'($urandom);
    s.mem = DW'($urandom);
    s.imm = DW'($urandom);
    s.pc = DW'($urandom);
    return s;
  endfunction

  // Expected outputs for the current model state.
  function automatic exp_t model_out();
    exp_t e;
    bit live;
    logic [DW-1:0] d;
    live = m_ent.valid && m_fresh && !m_halted;
    e.retired = CW'((m_count + (live ? 1 : 0)) % (1 << CW));
    e.wr_en = live && m_ent.regwrite && (m_ent.src != 3'd7);
    e.fwd_valid = m_ent.valid && m_ent.regwrite;
    e.wr_reg = m_ent.regdst ? m_ent.rd : m_ent.rs;
    case (m_ent.src)
      3'd1: d = m_ent.mem;
      3'd2: d = m_ent.alu | m_ent.imm;
      3'd3: begin
        bit c;
        case (m_ent.cmp)
          2'd0: c = m_ent.zero;
          2'd1: c = m_ent.p;
          2'd2: c = m_ent.p || m_ent.zero;
          default: c = m_ent.cout;
        endcase
        d = c ? DW'(1) : DW'(0);
      end
      3'd4: for (int i = 0; i < int'(DW); i++) d[i] = m_ent.alu[int'(DW) - 1 - i];
      3'd5: d = m_ent.pc;
      3'd6: d = m_ent.imm;
      default: d = m_ent.alu;
    endcase
    e.wr_data = d;
    e.halted = m_halted;
    e.err = m_err;
    e.known = m_known;
    return e;
  endfunction

  function automatic void model_step(input stim_t s);
    if (s.rst) begin
      m_ent = idle();
      m_fresh = 0;
      m_halted = 0;
      m_err = 0;
      m_count = 0;
      m_known = 1;
    end else begin
      if (m_ent.valid && m_fresh) begin
        if (!m_halted) m_count = (m_count + 1) % (1 << CW);
        if (m_ent.halt) m_halted = 1;
        if (m_ent.src == 3'd7) m_err = 1;
      end
      if (s.flush) begin
        m_ent.valid = 0;
        m_fresh = 0;
        m_known = 0;
      end else if (!s.stall) begin
        m_ent = s;
        m_fresh = 1;
        m_known = 1;
      end else begin
        m_fresh = 0;
      end
    end
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; in_valid = s.valid; stall = s.stall; flush = s.flush;
    in_regwrite = s.regwrite; in_regdst = s.regdst; in_rd = s.rd; in_rs = s.rs;
    in_src = s.src; in_cmp = s.cmp; in_zero = s.zero; in_p = s.p; in_cout = s.cout;
    in_halt = s.halt; in_alu = s.alu; in_mem = s.mem; in_imm = s.imm; in_nxt_pc = s.pc;
  endtask

  // Apply one cycle of stimulus; the model's expectation goes to the scoreboard.
  task automatic cycle(input stim_t s);
    drive(s);
    @(posedge clk);
    model_step(s);
    sb.push_back(model_out());
    #1;
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1;
    cycle(s);
  endtask

  function automatic stim_t wr_entry(input logic [2:0] src, input logic [DW-1:0] alu);
    stim_t s;
    s = idle();
    s.valid = 1;
    s.regwrite = 1;
    s.regdst = 1;
    s.rd = 3'd5;
    s.src = src;
    s.alu = alu;
    return s;
  endfunction

  // Monitor: compares DUT outputs against the scoreboard away from the clock edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_wr_en", 32'(wr_en), 32'(e.wr_en));
      check("sb_fwd_valid", 32'(fwd_valid), 32'(e.fwd_valid));
      check("sb_retired", 32'(retired), 32'(e.retired));
      check("sb_halted", 32'(halted), 32'(e.halted));
      check("sb_err", 32'(err), 32'(e.err));
      if (e.known) begin
        check("sb_wr_reg", 32'(wr_reg), 32'(e.wr_reg));
        check("sb_wr_data", 32'(wr_data), 32'(e.wr_data));
      end
    end
  end

  initial begin
    stim_t s;
    drive(idle());
    m_ent = idle();

    // Reset state
    do_reset();
    do_reset();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_wr_data", 32'(wr_data), 0);

    // ALU write
    cycle(wr_entry(3'd0, 16'h1234));
    check("alu_wr_en", 32'(wr_en), 1);
    check("alu_wr_reg", 32'(wr_reg), 5);
    check("alu_wr_data", 32'(wr_data), 32'h1234);
    check("alu_retired", 32'(retired), 1);

    // Stall write-once
    do_reset();
    s = wr_entry(3'd1, 16'h0);
    s.mem = 16'hBEEF;
    s.regdst = 0;
    s.rs = 3'd2;
    cycle(s);
    check("stall_first_wr_en", 32'(wr_en), 1);
    check("stall_wr_data", 32'(wr_data), 32'hBEEF);
    check("stall_wr_reg", 32'(wr_reg), 2);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim();
      s.rst = 0;
      s.flush = 0;
      s.stall = 1;
      cycle(s);
      check("stall_held_wr_en", 32'(wr_en), 0);
      check("stall_fwd_valid", 32'(fwd_valid), 1);
      check("stall_retired", 32'(retired), 1);
    end

    // Compare / BTR / SLBI
    do_reset();
    s = wr_entry(3'd3, 16'h0); s.cmp = 2'd2; s.zero = 1; s.p = 0;
    cycle(s);
    check("cmp_sle", 32'(wr_data), 32'h0001);
    s = wr_entry(3'd3, 16'h0); s.cmp = 2'd3; s.cout = 0; s.zero = 1; s.p = 1;
    cycle(s);
    check("cmp_sco", 32'(wr_data), 32'h0000);
    cycle(wr_entry(3'd4, 16'h0001));
    check("btr", 32'(wr_data), 32'h8000);
    s = wr_entry(3'd2, 16'h1200); s.imm = 16'h0034;
    cycle(s);
    check("slbi", 32'(wr_data), 32'h1234);

    // Flush vs stall; flush alongside a fresh entry does not cancel its write
    do_reset();
    cycle(wr_entry(3'd0, 16'h00AA));
    s = wr_entry(3'd0, 16'h0055);
    s.stall = 1;
    s.flush = 1;
    drive(s);
    #1;
    check("flush_fresh_write", 32'(wr_en), 1);
    cycle(s);
    check("flush_stall_wr_en", 32'(wr_en), 0);
    check("flush_stall_fwd", 32'(fwd_valid), 0);

    // Halt sticky
    do_reset();
    s = idle(); s.valid = 1; s.halt = 1;
    cycle(s);
    check("halt_retired", 32'(retired), 1);
    for (int i = 0; i < 2; i++) begin
      cycle(wr_entry(3'd0, 16'h7777));
      check("halted", 32'(halted), 1);
      check("halted_wr_en", 32'(wr_en), 0);
      check("halted_retired", 32'(retired), 1);
    end

    // Reserved source
    do_reset();
    cycle(wr_entry(3'd7, 16'h4321));
    check("rsv_wr_en", 32'(wr_en), 0);
    cycle(idle());
    check("rsv_err", 32'(err), 1);

    // Counter wrap: 17 retirements on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) cycle(wr_entry(3'($urandom_range(0, 6)), DW'($urandom)));
    check("wrap_retired", 32'(retired), 1);

    // Reset mid-stall
    do_reset();
    cycle(wr_entry(3'd0, 16'h1111));
    s = idle(); s.stall = 1;
    cycle(s);
    s.rst = 1;
    cycle(s);
    check("rststall_wr_en", 32'(wr_en), 0);
    check("rststall_fwd", 32'(fwd_valid), 0);
    check("rststall_retired", 32'(retired), 0);
    check("rststall_wr_data", 32'(wr_data), 0);
    s.rst = 0;
    cycle(s);
    check("postrst_wr_en", 32'(wr_en), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) cycle(rand_stim());

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
